// File: rtl/tuner_nco_ctrl_pkg.sv
// Shared definitions for the NCO phase sequencer: register map, CTRL bit positions, FSM states.
// Optional sweep feature is enabled by defining TUNER_SWEEP_EN.
package tuner_nco_ctrl_pkg;

    localparam logic [2:0] REG_FREQ      = 3'd0;
    localparam logic [2:0] REG_OFFSET    = 3'd1;
    localparam logic [2:0] REG_CTRL      = 3'd2;
    localparam logic [2:0] REG_SWP_STEP  = 3'd3;
    localparam logic [2:0] REG_SWP_LIMIT = 3'd4;

    localparam int unsigned CTRL_RUN_BIT = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/tuner_nco_ctrl_shadow_regs.sv
// Host write decode and shadow register storage; one update in flight, released by the apply strobe.
// Sweep shadows (SWP_STEP/SWP_LIMIT) exist only when TUNER_SWEEP_EN is defined.
module tuner_shadow_regs
    import tuner_nco_ctrl_pkg::*;
#(
    parameter int unsigned asz = 26,
    parameter int unsigned psz = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ena_i,
    input  logic           wr_stb_i,
    input  logic [2:0]     wr_addr_i,
    input  logic [31:0]    wr_data_i,
    output logic           wr_rdy_o,
    output logic           accept_o,
    output logic           apply_o,
    output logic [asz-1:0] sh_freq_o,
    output logic [psz-1:0] sh_ofs_o,
    output logic           sh_run_o,
`ifdef TUNER_SWEEP_EN
    output logic [asz-1:0] sh_swp_step_o,
    output logic [asz-1:0] sh_swp_limit_o,
`endif
    output logic           sh_clr_o
);

    logic           dirty_q;
    logic [asz-1:0] freq_q;
    logic [psz-1:0] ofs_q;
    logic           run_q;
    logic           clr_q;
`ifdef TUNER_SWEEP_EN
    logic [asz-1:0] swp_step_q;
    logic [asz-1:0] swp_limit_q;
`endif

    logic unused_wr_msbs;
    assign unused_wr_msbs = ^wr_data_i[31:asz];

    assign wr_rdy_o = ~dirty_q;
    assign accept_o = wr_stb_i & ~dirty_q;
    assign apply_o  = dirty_q & ena_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            dirty_q     <= 1'b0;
            freq_q      <= '0;
            ofs_q       <= '0;
            run_q       <= 1'b0;
            clr_q       <= 1'b0;
`ifdef TUNER_SWEEP_EN
            swp_step_q  <= '0;
            swp_limit_q <= '0;
`endif
        end else if (accept_o) begin
            // Every accepted write marks an update pending, even for discarded addresses.
            dirty_q <= 1'b1;
            case (wr_addr_i)
                REG_FREQ:   freq_q <= wr_data_i[asz-1:0];
                REG_OFFSET: ofs_q  <= wr_data_i[psz-1:0];
                REG_CTRL: begin
                    run_q <= wr_data_i[CTRL_RUN_BIT];
                    clr_q <= wr_data_i[CTRL_CLR_BIT];
                end
`ifdef TUNER_SWEEP_EN
                REG_SWP_STEP:  swp_step_q  <= wr_data_i[asz-1:0];
                REG_SWP_LIMIT: swp_limit_q <= wr_data_i[asz-1:0];
`else
                REG_SWP_STEP, REG_SWP_LIMIT: ;
`endif
                default: ;
            endcase
        end else if (apply_o) begin
            dirty_q <= 1'b0;
            clr_q   <= 1'b0;
        end
    end

    assign sh_freq_o = freq_q;
    assign sh_ofs_o  = ofs_q;
    assign sh_run_o  = run_q;
    assign sh_clr_o  = clr_q;
`ifdef TUNER_SWEEP_EN
    assign sh_swp_step_o  = swp_step_q;
    assign sh_swp_limit_o = swp_limit_q;
`endif

endmodule

// File: rtl/tuner_nco_ctrl.sv
// NCO phase sequencer: FSM, phase accumulator and phase output for the I/Q tuner slices.
// Define TUNER_SWEEP_EN to build the sawtooth frequency sweep.
module tuner_nco_ctrl
    import tuner_nco_ctrl_pkg::*;
#(
    parameter int unsigned asz = 26,
    parameter int unsigned psz = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ena,
    input  logic           wr_stb,
    input  logic [2:0]     wr_addr,
    input  logic [31:0]    wr_data,
    output logic           wr_rdy,
    output logic [psz-1:0] phs,
    output logic           phs_vld,
    output logic           busy
);

    state_t         state_q, state_d;
    logic [asz-1:0] acc_q, acc_d;
    logic [asz-1:0] freq_q, freq_d;
    logic [psz-1:0] ofs_q, ofs_d;
    logic           run_q, run_d;
    logic [psz-1:0] phs_q, phs_d;
    logic           vld_q, vld_d;
    logic           stepping;

    logic           accept, apply;
    logic [asz-1:0] sh_freq;
    logic [psz-1:0] sh_ofs;
    logic           sh_run, sh_clr;
`ifdef TUNER_SWEEP_EN
    logic [asz-1:0] sh_swp_step, sh_swp_limit;
    logic [asz-1:0] base_q, base_d;
    logic [asz-1:0] step_q, step_d;
    logic [asz-1:0] limit_q, limit_d;
    logic [asz:0]   swp_sum;
`endif

    tuner_shadow_regs #(
        .asz(asz),
        .psz(psz)
    ) u_shadow (
        .clk            (clk),
        .reset          (reset),
        .ena_i          (ena),
        .wr_stb_i       (wr_stb),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .wr_rdy_o       (wr_rdy),
        .accept_o       (accept),
        .apply_o        (apply),
        .sh_freq_o      (sh_freq),
        .sh_ofs_o       (sh_ofs),
        .sh_run_o       (sh_run),
`ifdef TUNER_SWEEP_EN
        .sh_swp_step_o  (sh_swp_step),
        .sh_swp_limit_o (sh_swp_limit),
`endif
        .sh_clr_o       (sh_clr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            freq_q  <= '0;
            ofs_q   <= '0;
            run_q   <= 1'b0;
            phs_q   <= '0;
            vld_q   <= 1'b0;
`ifdef TUNER_SWEEP_EN
            base_q  <= '0;
            step_q  <= '0;
            limit_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            ofs_q   <= ofs_d;
            run_q   <= run_d;
            phs_q   <= phs_d;
            vld_q   <= vld_d;
`ifdef TUNER_SWEEP_EN
            base_q  <= base_d;
            step_q  <= step_d;
            limit_q <= limit_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        freq_d   = freq_q;
        ofs_d    = ofs_q;
        run_d    = run_q;
        phs_d    = phs_q;
        vld_d    = 1'b0;
        stepping = 1'b0;
`ifdef TUNER_SWEEP_EN
        base_d   = base_q;
        step_d   = step_q;
        limit_d  = limit_q;
        swp_sum  = {1'b0, freq_q} + {1'b0, step_q};
`endif

        case (state_q)
            ST_IDLE, ST_RUN: if (accept) state_d = ST_PEND;
            ST_PEND:         if (apply)  state_d = sh_run ? ST_RUN : ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        if (ena) begin
            // The exiting-PEND step behaves as the state that was active before the write.
            stepping = (state_q == ST_RUN) || ((state_q == ST_PEND) && run_q);
            acc_d    = stepping ? acc_q + freq_q : '0;
            if ((state_q == ST_PEND) && sh_clr) acc_d = '0;
            if (stepping) begin
                phs_d = acc_d[asz-1 -: psz] + ofs_q;
                vld_d = 1'b1;
            end else begin
                phs_d = '0;
            end
`ifdef TUNER_SWEEP_EN
            if ((state_q == ST_RUN) && (step_q != '0)) begin
                freq_d = (swp_sum > {1'b0, limit_q}) ? base_q : swp_sum[asz-1:0];
            end
`endif
            if (state_q == ST_PEND) begin
                freq_d  = sh_freq;
                ofs_d   = sh_ofs;
                run_d   = sh_run;
`ifdef TUNER_SWEEP_EN
                base_d  = sh_freq;
                step_d  = sh_swp_step;
                limit_d = sh_swp_limit;
`endif
            end
        end
    end

    assign phs     = phs_q;
    assign phs_vld = vld_q;
    assign busy    = (state_q == ST_PEND);

endmodule
